// File: rtl/yscaler_line_sched_if.sv
// ----------------------------------------------------------------------------
// yscaler_line_sched_if
//   Command channel between the vertical-scaler line scheduler and the
//   line emitter.
//
//   master (scheduler): drives cmd_valid, cmd_slot, cmd_first, cmd_last
//                       [, cmd_slot1, cmd_frac]; receives cmd_ready, out_done
//   slave  (emitter)  : the mirror image
//
//   Optional: YSCALER_SCHED_INTERP_EN adds cmd_slot1 / cmd_frac for bilinear
//   weighting (and the C_IMG_HW parameter that sizes cmd_frac).
// ----------------------------------------------------------------------------
interface yscaler_line_sched_if #(
    parameter int C_SLOT_W = 1
`ifdef YSCALER_SCHED_INTERP_EN
  , parameter int C_IMG_HW = 12
`endif
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [C_SLOT_W-1:0] cmd_slot;
    logic                cmd_first;
    logic                cmd_last;
    logic                out_done;
`ifdef YSCALER_SCHED_INTERP_EN
    logic [C_SLOT_W-1:0] cmd_slot1;
    logic [C_IMG_HW:0]   cmd_frac;

    modport master (
        output cmd_valid, cmd_slot, cmd_first, cmd_last, cmd_slot1, cmd_frac,
        input  cmd_ready, out_done
    );
    modport slave (
        input  cmd_valid, cmd_slot, cmd_first, cmd_last, cmd_slot1, cmd_frac,
        output cmd_ready, out_done
    );
`else
    modport master (
        output cmd_valid, cmd_slot, cmd_first, cmd_last,
        input  cmd_ready, out_done
    );
    modport slave (
        input  cmd_valid, cmd_slot, cmd_first, cmd_last,
        output cmd_ready, out_done
    );
`endif
endinterface

// File: rtl/yscaler_line_sched.sv
// ----------------------------------------------------------------------------
// yscaler_line_sched
//   Line-level controller for the vertical scaler. Counts input lines written
//   into a ring of 2**C_SLOT_W line buffers, maps each output line j to source
//   line floor(j*ori_height/scale_height) with a DDA accumulator, issues one
//   command per output line and throttles the input so a buffer slot is never
//   overwritten while a pending output line still needs it.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     ori_height            input frame height  (sampled at in_sof)
//     scale_height          output frame height (sampled at in_sof)
//     in_sof, in_eol        input frame start / input line end pulses
//     in_ready              input permission (ANDed into upstream tready)
//     wr_slot               slot receiving the current input line
//     cmd                   command channel to the line emitter (master)
//     frame_done            pulse: frame fully emitted and consumed
//     busy                  frame in progress
//     sof_abort             pulse: in_sof arrived mid-frame
//     cfg_err               pulse: zero height sampled at in_sof
//
//   Optional: define YSCALER_SCHED_INTERP_EN to add cmd_slot1 / cmd_frac on
//   the command channel and to wait for the second source line as well.
// ----------------------------------------------------------------------------
module yscaler_line_sched #(
    parameter int C_IMG_HW = 12,
    parameter int C_SLOT_W = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [C_IMG_HW-1:0] ori_height,
    input  logic [C_IMG_HW-1:0] scale_height,
    input  logic                in_sof,
    input  logic                in_eol,
    output logic                in_ready,
    output logic [C_SLOT_W-1:0] wr_slot,
    yscaler_line_sched_if.master cmd,
    output logic                frame_done,
    output logic                busy,
    output logic                sof_abort,
    output logic                cfg_err
);

    localparam int unsigned NLINES = 2 ** C_SLOT_W;
    localparam logic [C_IMG_HW-1:0] NLINES_W = C_IMG_HW'(NLINES);
    localparam logic [C_IMG_HW-1:0] ONE      = C_IMG_HW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SRC,
        S_EMIT,
        S_WAIT_DONE,
        S_ADVANCE,
        S_DRAIN
    } state_t;

    state_t              state,      state_nxt;
    logic [C_IMG_HW-1:0] h_in,       h_in_nxt;
    logic [C_IMG_HW-1:0] h_out,      h_out_nxt;
    logic [C_IMG_HW-1:0] in_lines,   in_lines_nxt;
    logic [C_IMG_HW-1:0] out_lines,  out_lines_nxt;
    logic [C_IMG_HW-1:0] src_line,   src_line_nxt;
    logic [C_IMG_HW:0]   acc,        acc_nxt;
    logic                cmd_valid_q, cmd_valid_nxt;
    logic                frame_done_q, frame_done_nxt;
    logic                sof_abort_q, sof_abort_nxt;
    logic                cfg_err_q,  cfg_err_nxt;

    logic                heights_ok;
    logic [C_IMG_HW-1:0] need_line;
    logic [C_IMG_HW-1:0] lines_ahead;

    assign heights_ok = (ori_height != '0) && (scale_height != '0);

`ifdef YSCALER_SCHED_INTERP_EN
    logic [C_IMG_HW-1:0] src_next;
    assign src_next      = (src_line >= h_in - ONE) ? (h_in - ONE) : (src_line + ONE);
    assign need_line     = src_next;
    assign cmd.cmd_slot1 = src_next[C_SLOT_W-1:0];
    assign cmd.cmd_frac  = acc;
`else
    assign need_line = src_line;
`endif

    // After a downscale step src_line may run ahead of in_lines; the
    // difference is then "negative" and the input must not be held off.
    assign lines_ahead = in_lines - src_line;

    always_comb begin
        if (state == S_IDLE)
            in_ready = 1'b1;
        else
            in_ready = (in_lines < h_in) &&
                       ((in_lines <= src_line) || (lines_ahead < NLINES_W));
    end

    assign wr_slot       = in_lines[C_SLOT_W-1:0];
    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_slot  = src_line[C_SLOT_W-1:0];
    assign cmd.cmd_first = cmd_valid_q && (out_lines == '0);
    assign cmd.cmd_last  = cmd_valid_q && (out_lines == h_out - ONE);
    assign frame_done    = frame_done_q;
    assign sof_abort     = sof_abort_q;
    assign cfg_err       = cfg_err_q;
    assign busy          = (state != S_IDLE);

    always_comb begin
        state_nxt      = state;
        h_in_nxt       = h_in;
        h_out_nxt      = h_out;
        in_lines_nxt   = in_lines;
        out_lines_nxt  = out_lines;
        src_line_nxt   = src_line;
        acc_nxt        = acc;
        frame_done_nxt = 1'b0;
        sof_abort_nxt  = 1'b0;
        cfg_err_nxt    = 1'b0;

        if ((state != S_IDLE) && in_eol && (in_lines < h_in))
            in_lines_nxt = in_lines + ONE;

        unique case (state)
            S_IDLE: ;
            S_WAIT_SRC: begin
                if (in_lines > need_line)
                    state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (cmd.cmd_ready)
                    state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (cmd.out_done) begin
                    out_lines_nxt = out_lines + ONE;
                    acc_nxt       = acc + {1'b0, h_in};
                    state_nxt     = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (acc >= {1'b0, h_out}) begin
                    acc_nxt      = acc - {1'b0, h_out};
                    src_line_nxt = src_line + ONE;
                end else if (out_lines == h_out) begin
                    state_nxt = S_DRAIN;
                end else begin
                    state_nxt = S_WAIT_SRC;
                end
            end
            S_DRAIN: begin
                if (in_lines == h_in) begin
                    frame_done_nxt = 1'b1;
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Frame start has priority over everything else, in any state; a
        // mid-frame start additionally reports the abort.
        if (in_sof) begin
            sof_abort_nxt  = (state != S_IDLE);
            frame_done_nxt = 1'b0;
            in_lines_nxt   = '0;
            out_lines_nxt  = '0;
            src_line_nxt   = '0;
            acc_nxt        = '0;
            if (heights_ok) begin
                h_in_nxt  = ori_height;
                h_out_nxt = scale_height;
                state_nxt = S_WAIT_SRC;
            end else begin
                cfg_err_nxt = 1'b1;
                state_nxt   = S_IDLE;
            end
        end

        cmd_valid_nxt = (state_nxt == S_EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            h_in         <= '0;
            h_out        <= '0;
            in_lines     <= '0;
            out_lines    <= '0;
            src_line     <= '0;
            acc          <= '0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            sof_abort_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            h_in         <= h_in_nxt;
            h_out        <= h_out_nxt;
            in_lines     <= in_lines_nxt;
            out_lines    <= out_lines_nxt;
            src_line     <= src_line_nxt;
            acc          <= acc_nxt;
            cmd_valid_q  <= cmd_valid_nxt;
            frame_done_q <= frame_done_nxt;
            sof_abort_q  <= sof_abort_nxt;
            cfg_err_q    <= cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_yscaler_line_sched.sv
// ----------------------------------------------------------------------------
// tb_yscaler_line_sched
//   Directed bench for yscaler_line_sched: up/down/unity scaling frames with
//   an emitter model, mid-frame restart, zero-height config and mid-frame
//   reset. Expected source lines come from floor(j*ori/scale).
// ----------------------------------------------------------------------------
module tb_yscaler_line_sched;

    localparam int HW = 12;
    localparam int SW = 1;
    localparam int NL = 2 ** SW;

    logic          clk = 1'b0;
    logic          reset;
    logic [HW-1:0] ori_height;
    logic [HW-1:0] scale_height;
    logic          in_sof;
    logic          in_eol;
    logic          in_ready;
    logic [SW-1:0] wr_slot;
    logic          frame_done;
    logic          busy;
    logic          sof_abort;
    logic          cfg_err;

    yscaler_line_sched_if #(.C_SLOT_W(SW)) cmd_if ();

    yscaler_line_sched #(.C_IMG_HW(HW), .C_SLOT_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ori_height   (ori_height),
        .scale_height (scale_height),
        .in_sof       (in_sof),
        .in_eol       (in_eol),
        .in_ready     (in_ready),
        .wr_slot      (wr_slot),
        .cmd          (cmd_if),
        .frame_done   (frame_done),
        .busy         (busy),
        .sof_abort    (sof_abort),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int eol_sent = 0;

    always @(negedge clk) begin
        if (!reset && frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_sof(input int ih, input int oh);
        ori_height   = HW'(ih);
        scale_height = HW'(oh);
        in_sof       = 1'b1;
        @(negedge clk);
        in_sof       = 1'b0;
    endtask

    task automatic send_eol();
        for (int i = 0; i < 1000 && !in_ready; i++) @(negedge clk);
        check_eq("in_ready_wait", in_ready, 1);
        in_eol = 1'b1;
        @(negedge clk);
        in_eol = 1'b0;
        eol_sent++;
    endtask

    task automatic drive_lines(input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_eol();
        end
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 2000 && !cmd_if.cmd_valid; i++) @(negedge clk);
        check_eq("cmd_valid_wait", cmd_if.cmd_valid, 1);
    endtask

    // Emitter model: accepts n commands of a ih->oh frame, checking each
    // command's source line, slot, first/last flags and hold-while-stalled.
    task automatic emit_cmds(input int ih, input int oh, input int n, input int max_dly);
        int          exp_src;
        logic [31:0] snap;
        for (int j = 0; j < n; j++) begin
            exp_src = (j * ih) / oh;
            wait_cmd();
            check_eq("src_line", dut.src_line, exp_src);
            check_eq("cmd_slot", cmd_if.cmd_slot, exp_src % NL);
            check_eq("cmd_first", cmd_if.cmd_first, (j == 0));
            check_eq("cmd_last", cmd_if.cmd_last, (j == oh - 1));
            check_eq("window", ((eol_sent - exp_src) <= NL), 1);
            snap = {28'd0, cmd_if.cmd_valid, cmd_if.cmd_slot, cmd_if.cmd_first, cmd_if.cmd_last};
            repeat ($urandom_range(0, max_dly)) begin
                @(negedge clk);
                check_eq("cmd_hold",
                         {28'd0, cmd_if.cmd_valid, cmd_if.cmd_slot, cmd_if.cmd_first, cmd_if.cmd_last},
                         snap);
            end
            cmd_if.cmd_ready = 1'b1;
            @(negedge clk);
            cmd_if.cmd_ready = 1'b0;
            check_eq("cmd_drop", cmd_if.cmd_valid, 0);
            repeat ($urandom_range(0, max_dly)) @(negedge clk);
            cmd_if.out_done = 1'b1;
            @(negedge clk);
            cmd_if.out_done = 1'b0;
        end
    endtask

    task automatic run_frame(input int ih, input int oh, input int gap, input int dly);
        int fd0;
        fd0      = fd_cnt;
        eol_sent = 0;
        send_sof(ih, oh);
        fork
            drive_lines(ih, gap);
            emit_cmds(ih, oh, oh, dly);
        join
        for (int i = 0; i < 50 && fd_cnt == fd0; i++) @(negedge clk);
        @(negedge clk);
        check_eq("frame_done_cnt", fd_cnt - fd0, 1);
        check_eq("busy_after", busy, 0);
        check_eq("no_extra_cmd", cmd_if.cmd_valid, 0);
    endtask

    initial begin
        reset            = 1'b1;
        ori_height       = '0;
        scale_height     = '0;
        in_sof           = 1'b0;
        in_eol           = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        cmd_if.out_done  = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_cmd_valid", cmd_if.cmd_valid, 0);
        check_eq("rst_cmd_first", cmd_if.cmd_first, 0);
        check_eq("rst_cmd_last", cmd_if.cmd_last, 0);
        check_eq("rst_cmd_slot", cmd_if.cmd_slot, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_wr_slot", wr_slot, 0);
        check_eq("rst_flags", {frame_done, sof_abort, cfg_err}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_frame(10, 30, 0, 0);   // upscale
        run_frame(10, 5, 0, 0);    // downscale, last line drained
        run_frame(10, 10, 3, 4);   // unity, random stalls

        // Mid-frame restart during output line 4 of a 10->30 frame.
        eol_sent = 0;
        send_sof(10, 30);
        send_eol();
        check_eq("wr_slot_1", wr_slot, 1);
        send_eol();
        check_eq("throttle", in_ready, 0);
        emit_cmds(10, 30, 4, 0);
        wait_cmd();
        check_eq("abort_pre_src", dut.src_line, 1);
        send_sof(10, 30);
        check_eq("sof_abort", sof_abort, 1);
        check_eq("abort_cmd_drop", cmd_if.cmd_valid, 0);
        check_eq("abort_busy", busy, 1);
        check_eq("abort_in_ready", in_ready, 1);
        @(negedge clk);
        check_eq("sof_abort_pulse", sof_abort, 0);
        eol_sent = 0;
        send_eol();
        wait_cmd();
        check_eq("restart_first", cmd_if.cmd_first, 1);
        check_eq("restart_src", dut.src_line, 0);
        check_eq("restart_slot", cmd_if.cmd_slot, 0);

        // Reset while a command is being presented.
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_valid", cmd_if.cmd_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", in_ready, 1);
        check_eq("mid_rst_first", cmd_if.cmd_first, 0);
        reset = 1'b0;
        @(negedge clk);

        // Zero heights are rejected and the frame is discarded.
        send_sof(10, 0);
        check_eq("cfg_err_oh", cfg_err, 1);
        check_eq("cfg_err_busy", busy, 0);
        repeat (3) send_eol();
        repeat (5) @(negedge clk);
        check_eq("cfg_err_no_cmd", cmd_if.cmd_valid, 0);
        check_eq("cfg_err_idle", busy, 0);
        send_sof(0, 10);
        check_eq("cfg_err_ih", cfg_err, 1);
        @(negedge clk);
        check_eq("cfg_err_pulse", cfg_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/yscaler_line_sched.md
Name: yscaler_line_sched

Overview:
Line-level controller for the vertical scaler datapath. It tracks which input lines of a frame have been written into a small ring of line buffers, and maps each output line to its source line with a DDA accumulator (nearest-neighbour, src(j) = floor(j*ori_height/scale_height)). It issues one read command per output line to the line emitter and throttles the input stream so that no buffer slot is overwritten while a pending output line still needs it. It sits between the AXI-stream input framer (sof/eol decode) and the line-buffer read side.

Parameters:
C_IMG_HW, 12, width of height/count fields
C_SLOT_W, 1, line-buffer slot index width; NLINES = 2**C_SLOT_W (minimum 2 buffered lines)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ori_height  in  C_IMG_HW  input frame height; sampled at in_sof
scale_height  in  C_IMG_HW  output frame height; sampled at in_sof
in_sof  in  1  pulse: first beat of frame accepted (tuser & handshake)
in_eol  in  1  pulse: last beat of input line accepted (tlast & handshake)
in_ready  out  1  input-side permission; ANDed into upstream tready
wr_slot  out  C_SLOT_W  buffer slot the current input line is written into
cmd_valid  out  1  output-line command valid
cmd_ready  in  1  emitter accepts command
cmd_slot  out  C_SLOT_W  slot holding the source line
cmd_first  out  1  command is output line 0 (drives output tuser)
cmd_last  out  1  command is output line scale_height-1
out_done  in  1  pulse: emitter finished the line of the last accepted command
frame_done  out  1  one-cycle pulse: all output lines emitted and all input lines consumed
busy  out  1  frame in progress (state != IDLE)
sof_abort  out  1  one-cycle pulse: in_sof arrived mid-frame
cfg_err  out  1  one-cycle pulse: zero height sampled at in_sof

Behaviour:
- Reset: state IDLE; all counters 0; cmd_valid=0, cmd_first=0, cmd_last=0, cmd_slot=0, frame_done=0, sof_abort=0, cfg_err=0, busy=0. in_ready=1, wr_slot=0.
- Registers: h_in/h_out latched at in_sof. in_lines, out_lines, src_line are C_IMG_HW bits. acc is C_IMG_HW+1 bits; acc < h_out always, so acc+h_in cannot overflow.
- wr_slot = in_lines mod NLINES. cmd_slot = src_line mod NLINES.
- in_ready = 1 in IDLE. In any other state, in_ready = (in_lines < h_in) && (in_lines - src_line < NLINES).
- IDLE: on in_sof with both heights nonzero, latch heights, clear counters and acc, then go WAIT_SRC. If either height is zero, pulse cfg_err and stay in IDLE; in_ready stays 1, so that frame is discarded.
- WAIT_SRC: if in_lines > src_line, go EMIT. cmd_valid is registered and rises exactly 2 cycles after the satisfying in_eol.
- EMIT: cmd_valid=1 and cmd_first=(out_lines==0), cmd_last=(out_lines==h_out-1). All command outputs stay stable until cmd_ready. On handshake, drop cmd_valid and go WAIT_DONE.
- WAIT_DONE: on out_done, out_lines+=1, acc+=h_in, go ADVANCE.
- ADVANCE: when acc>=h_out, acc-=h_out and src_line+=1, one subtraction per cycle, staying in ADVANCE. When acc<h_out: go DRAIN if out_lines==h_out, else go WAIT_SRC.
- DRAIN: in_ready stays asserted so the remaining input lines are discarded. When in_lines==h_in, pulse frame_done and go IDLE. If in_lines already equals h_in on entry, pulse in the next cycle.
- in_eol increments in_lines in every non-IDLE state, capped at h_in; extra eol beyond h_in is ignored.
- The in_sof beat of a frame belongs to line 0. The in_eol of line 0 is counted after the IDLE->WAIT_SRC transition.
- in_sof in any non-IDLE state: pulse sof_abort, drop cmd_valid, re-latch heights, clear counters, enter WAIT_SRC (or IDLE with cfg_err if a height is zero). An outstanding emitter line is the emitter's responsibility to flush.
- Simultaneous in_eol and out_done are both honoured in the same cycle.
- reset mid-frame returns every output to its reset value on the next edge.

Optional Feature:
YSCALER_SCHED_INTERP_EN.
- Enabled: adds outputs cmd_slot1 (C_SLOT_W, slot of min(src_line+1, h_in-1)) and cmd_frac (C_IMG_HW+1, current acc) for bilinear weight = cmd_frac/h_out. WAIT_SRC additionally requires in_lines > min(src_line+1, h_in-1).
- Disabled: those ports are absent and the source condition is in_lines > src_line only.

Test Plan:
- 10->30 upscale, ready=1: 30 commands with src lines 0,0,0,1,1,1..9,9,9. cmd_first only on command 0, cmd_last only on command 29, then one frame_done.
- 10->5 downscale: src lines 0,2,4,6,8. Line 9 is drained with in_ready=1, and frame_done pulses after the 10th in_eol.
- 10->10 with random cmd_ready/out_done delays: src_line==out_line for every command, command fields stable while cmd_valid&!cmd_ready, and in_lines-src_line never exceeds 2.
- in_sof during out_line 4 of a 10->30 frame: sof_abort pulse, cmd_valid drops, next command is src 0 with cmd_first=1.
- scale_height=0 at in_sof: cfg_err pulse, busy stays 0, no commands issued.
- reset asserted in EMIT: next cycle cmd_valid=0, busy=0, in_ready=1.
